apple_video_fetch: RTL and testbench
====================================

Name: apple_video_fetch

Overview:
- Scanline prefetcher directly downstream of the Apple II shadow video memory.
- On each line request it walks the 40 Apple II column addresses of one text/lores or hires row, two columns per read, and issues reads on the shadow memory's video read port.
- Each returned 32-bit word carries main and aux bytes for two columns; it is written into a 20-entry scanline buffer consumed by the pixel pipeline.

Parameters:
- READ_LATENCY, 1, cycles from video_rd_o/video_address_o to valid video_data_i; legal range 1..3.

Ports:
- clk_logic  in  1  system logic clock
- system_reset_n  in  1  reset, synchronous, active-low
- line_start_i  in  1  one-cycle pulse requesting fetch of line_i
- line_i  in  8  scanline 0..191
- text_mode_i  in  1  1 = text/lores row addressing, 0 = hires (mixed mode resolved by caller)
- page2_i  in  1  selects display page 2
- vgc_active_i  in  1  SHR/VGC owns memory; suppress fetch
- video_address_o  out  16  Apple II address to shadow memory
- video_rd_o  out  1  read strobe
- video_data_i  in  32  {aux[a+1], main[a+1], aux[a], main[a]}
- lb_ready_i  in  1  line buffer may accept new reads
- lb_wr_o  out  1  line buffer write strobe
- lb_addr_o  out  5  column-pair index 0..19
- lb_data_o  out  32  video_data_i passed through unmodified
- busy_o  out  1  fetch in progress
- line_done_o  out  1  one-cycle pulse, line complete

Behaviour:
- Reset (sync, system_reset_n low at clk_logic edge): state IDLE. video_address_o=0, video_rd_o=0, lb_wr_o=0, lb_addr_o=0, lb_data_o=0, busy_o=0, line_done_o=0. Reset is honoured mid-fetch; in-flight reads are discarded and produce no lb_wr_o.
- States: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE: on line_start_i, latch line_i, text_mode_i and page2_i, compute row base, clear issue counter k, go to FETCH.
  - If vgc_active_i=1 or line_i>=192 at the request: go straight to DONE; no reads, no writes.
- Row base, 16-bit unsigned, no overflow possible:
  - Text: r=line[7:3]; base = (page2 ? 0x0800 : 0x0400) + {r[2:0],7'b0} + r[4:3]*40.
  - Hires: base = (page2 ? 0x4000 : 0x2000) + {line[2:0],10'b0} + {line[5:3],7'b0} + line[7:6]*40.
- FETCH: each cycle with lb_ready_i=1:
  - assert video_rd_o with video_address_o = base + 2*k, tagged with k; increment k.
  - After issuing k=19, go to DRAIN.
  - With lb_ready_i=0: video_rd_o=0, k and address hold.
- Return pipeline: a READ_LATENCY-deep shift register of {valid, k}. When a valid tag emerges, register lb_wr_o=1, lb_addr_o=k, lb_data_o=video_data_i on the next edge.
  - Total issue-to-write latency is READ_LATENCY+1.
  - Writes of already-issued reads complete regardless of lb_ready_i. The consumer must absorb up to READ_LATENCY+1 writes after deasserting ready.
- DRAIN: wait until the shift register and output register are empty, then go to DONE.
- DONE: line_done_o=1 for exactly one cycle, then IDLE.
- busy_o=1 in FETCH, DRAIN and DONE.
- line_start_i while busy (FETCH/DRAIN): abort the current line.
  - Flush all in-flight tags; writes for them are suppressed.
  - No line_done_o for the aborted line.
  - Latch the new request and restart FETCH at k=0 on the next cycle.
- line_start_i in the same cycle as DONE: DONE pulse is still emitted, then the new line starts. The request is latched, not dropped.
- vgc_active_i rising mid-fetch: stop issuing, drain in-flight reads, go to DONE.
- Exactly 20 writes per completed line, lb_addr_o strictly increasing 0..19.

Test Plan:
- Text line 0, page1, READ_LATENCY=1, lb_ready_i=1 -> addresses 0x0400,0x0402..0x0426 on 20 consecutive cycles; first lb_wr_o 2 cycles after first video_rd_o; line_done_o 1 cycle after lb_addr_o=19 write.
- Text line 100, page2 -> base 0x0A28, last address 0x0A4E. Hires line 191, page2 -> base 0x5FD0, last 0x5FF6. Hires line 64, page1 -> base 0x2028.
- Backpressure: drop lb_ready_i after k=5 issued for 10 cycles -> no video_rd_o during the gap; writes for k<=5 still appear; fetch resumes at 0x..+12; 20 writes total with no duplicates.
- Restart: line_start_i(line=8) at k=10, READ_LATENCY=3 -> no writes carrying stale data; no done for the first line; 20 writes for the new base 0x0480 (text).
- vgc_active_i=1 at request, or line_i=200 -> zero video_rd_o and zero lb_wr_o; line_done_o pulses within 2 cycles.
- Reset asserted mid-FETCH -> all outputs 0 on the next edge; no pending write emerges after reset release.

Source files
------------

// File: rtl/apple_video_fetch.sv
// Scanline prefetcher for the Apple II shadow video memory. For each line
// request it walks the 40 column addresses of one text/lores or hires row,
// two columns per read, and forwards every returned word into a 20-entry
// line buffer tagged with its column-pair index.
module apple_video_fetch #(
  parameter int READ_LATENCY = 1  // cycles from read strobe to valid data, 1..3
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        line_start_i,
  input  logic [7:0]  line_i,
  input  logic        text_mode_i,
  input  logic        page2_i,
  input  logic        vgc_active_i,
  output logic [15:0] video_address_o,
  output logic        video_rd_o,
  input  logic [31:0] video_data_i,
  input  logic        lb_ready_i,
  output logic        lb_wr_o,
  output logic [4:0]  lb_addr_o,
  output logic [31:0] lb_data_o,
  output logic        busy_o,
  output logic        line_done_o
);

  localparam logic [4:0] LAST_K = 5'd19;  // 20 column pairs per row

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [4:0]  k_q;
  logic [READ_LATENCY-1:0] pipe_vld_q;
  logic [4:0]  pipe_k_q [READ_LATENCY];
  logic [4:0]  row;
  logic        skip;
  logic        abort;
  logic        issue;
  logic        in_flight;
  logic        tag_out;

  // Multiply a 2-bit row-group index by 40 (40 = 32 + 8).
  function automatic logic [15:0] times40(input logic [1:0] x);
    return {9'b0, x, 5'b0} + {11'b0, x, 3'b0};
  endfunction

  // Row base address of the requested line, evaluated from the live request.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    base_d = 16'h0000;
    row    = line_i[7:3];
    if (text_mode_i) begin
      base_d = (page2_i ? 16'h0800 : 16'h0400)
             + {6'b0, row[2:0], 7'b0}
             + times40(row[4:3]);
    end else begin
      base_d = (page2_i ? 16'h4000 : 16'h2000)
             + {3'b0, line_i[2:0], 10'b0}
             + {6'b0, line_i[5:3], 7'b0}
             + times40(line_i[7:6]);
    end
  end

  // A request that cannot be fetched completes at once with no memory traffic.
  assign skip      = vgc_active_i || (line_i >= 8'd192);
  // A new request arriving mid-line throws away everything still in flight.
  assign abort     = line_start_i && (state_q == FETCH || state_q == DRAIN);
  // Reads stop the moment the VGC takes memory or a new request arrives.
  assign issue     = (state_q == FETCH) && lb_ready_i && !vgc_active_i && !line_start_i;
  assign in_flight = |pipe_vld_q;
  assign tag_out   = pipe_vld_q[READ_LATENCY-1] && !abort;

  assign video_rd_o      = issue;
  assign video_address_o = (state_q == FETCH) ? base_q + {10'b0, k_q, 1'b0} : 16'h0000;
  assign busy_o          = (state_q != IDLE);
  assign line_done_o     = (state_q == DONE);

  // Next-state logic; a line request restarts from any state.
  always_comb begin
    state_d = state_q;
    if (line_start_i) begin
      state_d = skip ? DONE : FETCH;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FETCH:   if (vgc_active_i || (issue && k_q == LAST_K)) state_d = DRAIN;
        DRAIN:   if (!in_flight) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_logic) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!system_reset_n) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // Issue counter, row base, tag valid pipeline and line buffer write port.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      base_q     <= 16'h0000;
      k_q        <= 5'd0;
      pipe_vld_q <= '0;
      lb_wr_o    <= 1'b0;
      lb_addr_o  <= 5'd0;
      lb_data_o  <= 32'h0000_0000;
    end else begin
      // The row base captures line, mode and page for the whole fetch.
      if (line_start_i) begin
        base_q <= base_d;
        k_q    <= 5'd0;
      end else if (issue) begin
        k_q <= k_q + 5'd1;
      end

      pipe_vld_q[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
      if (abort) pipe_vld_q <= '0;

      lb_wr_o <= tag_out;
      if (tag_out) begin
        lb_addr_o <= pipe_k_q[READ_LATENCY-1];
        lb_data_o <= video_data_i;
      end
    end
  end

  // Column-pair index travelling alongside each outstanding read.
  always_ff @(posedge clk_logic) begin
    // NOTE: the tag payloads are deliberately not reset; the valid bits alone
    // decide whether a slot means anything.
    pipe_k_q[0] <= k_q;
    for (int i = 1; i < READ_LATENCY; i++) pipe_k_q[i] <= pipe_k_q[i-1];
  end

endmodule

// File: tb/tb_apple_video_fetch.sv
// Self-checking bench: two instances (read latency 1 and 3) share stimulus,
// each behind its own shadow-memory model; issued addresses and line buffer
// writes are compared against scoreboard queues filled at request time.
module tb_apple_video_fetch;

  logic clk_logic = 1'b0;
  always #5 clk_logic = ~clk_logic;

  logic        system_reset_n, line_start_i, text_mode_i, page2_i, vgc_active_i, lb_ready_i;
  logic [7:0]  line_i;
  logic [15:0] va1, va3;
  logic        rd1, rd3, wr1, wr3, busy1, busy3, done1, done3;
  logic [31:0] vd1, vd3, ld1, ld3;
  logic [4:0]  la1, la3;

  apple_video_fetch #(.READ_LATENCY(1)) u_dut1 (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n), .line_start_i(line_start_i),
    .line_i(line_i), .text_mode_i(text_mode_i), .page2_i(page2_i), .vgc_active_i(vgc_active_i),
    .video_address_o(va1), .video_rd_o(rd1), .video_data_i(vd1), .lb_ready_i(lb_ready_i),
    .lb_wr_o(wr1), .lb_addr_o(la1), .lb_data_o(ld1), .busy_o(busy1), .line_done_o(done1)
  );

  apple_video_fetch #(.READ_LATENCY(3)) u_dut3 (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n), .line_start_i(line_start_i),
    .line_i(line_i), .text_mode_i(text_mode_i), .page2_i(page2_i), .vgc_active_i(vgc_active_i),
    .video_address_o(va3), .video_rd_o(rd3), .video_data_i(vd3), .lb_ready_i(lb_ready_i),
    .lb_wr_o(wr3), .lb_addr_o(la3), .lb_data_o(ld3), .busy_o(busy3), .line_done_o(done3)
  );

  // Shadow memory contents: each byte is a function of its address.
  function automatic logic [7:0] main_b(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] aux_b(input logic [15:0] a);
    return ~(a[7:0] + a[15:8]);
  endfunction
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {aux_b(a1), main_b(a1), aux_b(a), main_b(a)};
  endfunction

  // Row base from the Apple II screen layout.
  function automatic logic [15:0] model_base(input logic [7:0] ln, input logic txt, input logic pg);
    int r, b;
    if (txt) begin
      r = int'(ln) / 8;
      b = (pg ? 2048 : 1024) + (r % 8) * 128 + (r / 8) * 40;
    end else begin
      b = (pg ? 16384 : 8192) + (int'(ln) % 8) * 1024 + ((int'(ln) / 8) % 8) * 128 + (int'(ln) / 64) * 40;
    end
    return 16'(b);
  endfunction

  // Memory models: data appears READ_LATENCY cycles after the address.
  logic [15:0] ap1 = 16'h0;
  logic [15:0] ap3 [3] = '{16'h0, 16'h0, 16'h0};
  always @(posedge clk_logic) begin
    ap1    <= va1;
    ap3[0] <= va3;
    ap3[1] <= ap3[0];
    ap3[2] <= ap3[1];
  end
  assign vd1 = mem_word(ap1);
  assign vd3 = mem_word(ap3[2]);

  typedef logic [36:0] wr_t;  // {lb_addr, lb_data}
  wr_t         wq1[$], wq3[$];
  logic [15:0] iq1[$], iq3[$];

  int n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0, stray = 0, req_cyc = 0;
  int n_rd1, n_rd3, n_wr1, n_wr3, n_done1, n_done3;
  int first_rd1, last_rd1, first_rd3, first_wr1, first_wr3, last_wr1, last_wr3, done_cyc1, done_cyc3;
  logic [15:0] first_addr, last_addr, resume_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    n_rd1 = 0; n_rd3 = 0; n_wr1 = 0; n_wr3 = 0; n_done1 = 0; n_done3 = 0;
    first_rd1 = 0; last_rd1 = 0; first_rd3 = 0; first_wr1 = 0; first_wr3 = 0;
    last_wr1 = 0; last_wr3 = 0; done_cyc1 = 0; done_cyc3 = 0;
    first_addr = 16'h0; last_addr = 16'h0; resume_addr = 16'h0;
  endtask

  // Scoreboard side: consume one cycle of DUT output.
  task automatic sample();
    if (rd1) begin
      if (n_rd1 == 0) begin first_rd1 = cyc; first_addr = va1; end
      if (n_rd1 == 6) resume_addr = va1;
      last_rd1 = cyc; last_addr = va1; n_rd1++;
      if (iq1.size() == 0) stray++;
      else check("rd_addr_l1", 64'(va1), 64'(iq1.pop_front()));
    end
    if (rd3) begin
      if (n_rd3 == 0) first_rd3 = cyc;
      n_rd3++;
      if (iq3.size() == 0) stray++;
      else check("rd_addr_l3", 64'(va3), 64'(iq3.pop_front()));
    end
    if (wr1) begin
      if (n_wr1 == 0) first_wr1 = cyc;
      if (la1 == 5'd19) last_wr1 = cyc;
      n_wr1++;
      if (wq1.size() == 0) stray++;
      else check("wr_l1", 64'({la1, ld1}), 64'(wq1.pop_front()));
    end
    if (wr3) begin
      if (n_wr3 == 0) first_wr3 = cyc;
      if (la3 == 5'd19) last_wr3 = cyc;
      n_wr3++;
      if (wq3.size() == 0) stray++;
      else check("wr_l3", 64'({la3, ld3}), 64'(wq3.pop_front()));
    end
    if (done1) begin n_done1++; done_cyc1 = cyc; end
    if (done3) begin n_done3++; done_cyc3 = cyc; end
  endtask

  // Sample this cycle on the falling edge, then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk_logic);
    sample();
    @(posedge clk_logic);
    cyc++;
    #1;
  endtask

  // Pulse line_start_i for one cycle and load the scoreboard for the new line.
  task automatic start_line(input logic [7:0] ln, input logic txt, input logic pg);
    logic [15:0] base, a;
    bit fetch;
    fetch = !vgc_active_i && (ln < 8'd192);
    line_i = ln; text_mode_i = txt; page2_i = pg; line_start_i = 1'b1;
    req_cyc = cyc;
    tick();
    line_start_i = 1'b0;
    iq1.delete(); iq3.delete(); wq1.delete(); wq3.delete();
    clear_stats();
    if (fetch) begin
      base = model_base(ln, txt, pg);
      for (int k = 0; k < 20; k++) begin
        a = base + 16'(2 * k);
        iq1.push_back(a);
        iq3.push_back(a);
        wq1.push_back({5'(k), mem_word(a)});
        wq3.push_back({5'(k), mem_word(a)});
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && (busy1 || busy3); i++) tick();
    check("idle_timeout", 64'(busy1 | busy3), 64'(0));
  endtask

  task automatic line_checks(input int exp_wr, input logic [15:0] exp_first, input logic [15:0] exp_last);
    check("writes_l1", 64'(n_wr1), 64'(exp_wr));
    check("writes_l3", 64'(n_wr3), 64'(exp_wr));
    check("done_l1", 64'(n_done1), 64'(1));
    check("done_l3", 64'(n_done3), 64'(1));
    check("sb_empty", 64'(wq1.size() + wq3.size() + iq1.size() + iq3.size()), 64'(0));
    check("stray", 64'(stray), 64'(0));
    if (exp_wr != 0) begin
      check("first_addr", 64'(first_addr), 64'(exp_first));
      check("last_addr", 64'(last_addr), 64'(exp_last));
    end
  endtask

  initial begin
    system_reset_n = 1'b0; line_start_i = 1'b0; line_i = 8'd0; text_mode_i = 1'b1;
    page2_i = 1'b0; vgc_active_i = 1'b0; lb_ready_i = 1'b1;
    clear_stats();
    @(posedge clk_logic); #1;
    repeat (3) tick();
    check("reset_l1", 64'({va1, rd1, wr1, la1, ld1, busy1, done1}), 64'(0));
    check("reset_l3", 64'({va3, rd3, wr3, la3, ld3, busy3, done3}), 64'(0));
    system_reset_n = 1'b1;
    tick();

    // Text line 0, page 1: consecutive issue and pipeline latencies.
    start_line(8'd0, 1'b1, 1'b0);
    wait_idle(100);
    line_checks(20, 16'h0400, 16'h0426);
    check("issue_span", 64'(last_rd1 - first_rd1), 64'(19));
    check("wr_lat_l1", 64'(first_wr1 - first_rd1), 64'(2));
    check("wr_lat_l3", 64'(first_wr3 - first_rd3), 64'(4));
    check("done_lat_l1", 64'(done_cyc1 - last_wr1), 64'(1));
    check("done_lat_l3", 64'(done_cyc3 - last_wr3), 64'(1));

    // Row base corner cases.
    start_line(8'd100, 1'b1, 1'b1);
    wait_idle(100);
    line_checks(20, 16'h0A28, 16'h0A4E);
    start_line(8'd191, 1'b0, 1'b1);
    wait_idle(100);
    line_checks(20, 16'h5FD0, 16'h5FF6);
    start_line(8'd64, 1'b0, 1'b0);
    wait_idle(100);
    line_checks(20, 16'h2028, 16'h204E);

    // Backpressure after k=5 for ten cycles.
    start_line(8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 50 && n_rd1 < 6; i++) tick();
    lb_ready_i = 1'b0;
    repeat (10) tick();
    check("gap_no_rd", 64'(n_rd1), 64'(6));
    check("gap_writes_l1", 64'(n_wr1), 64'(6));
    check("gap_writes_l3", 64'(n_wr3), 64'(6));
    lb_ready_i = 1'b1;
    wait_idle(100);
    line_checks(20, 16'h0400, 16'h0426);
    check("resume_addr", 64'(resume_addr), 64'(16'h040C));

    // Restart at k=10 with a new request for text line 8.
    start_line(8'd40, 1'b1, 1'b0);
    for (int i = 0; i < 50 && n_rd1 < 10; i++) tick();
    check("pre_abort_done", 64'(n_done1 + n_done3), 64'(0));
    start_line(8'd8, 1'b1, 1'b0);
    wait_idle(100);
    line_checks(20, 16'h0480, 16'h04A6);

    // VGC owns memory at the request.
    vgc_active_i = 1'b1;
    start_line(8'd10, 1'b1, 1'b0);
    wait_idle(10);
    vgc_active_i = 1'b0;
    line_checks(0, 16'h0, 16'h0);
    check("vgc_rd", 64'(n_rd1 + n_rd3), 64'(0));
    check("vgc_done_lat", 64'(done_cyc1 - req_cyc), 64'(1));

    // Line beyond the visible area.
    start_line(8'd200, 1'b0, 1'b0);
    wait_idle(10);
    line_checks(0, 16'h0, 16'h0);
    check("l200_rd", 64'(n_rd1 + n_rd3), 64'(0));
    check("l200_done_lat", 64'(done_cyc3 - req_cyc), 64'(1));

    // Reset in the middle of a fetch.
    start_line(8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 50 && n_rd1 < 8; i++) tick();
    system_reset_n = 1'b0;
    tick();
    check("midreset_l1", 64'({va1, rd1, wr1, la1, ld1, busy1, done1}), 64'(0));
    check("midreset_l3", 64'({va3, rd3, wr3, la3, ld3, busy3, done3}), 64'(0));
    iq1.delete(); iq3.delete(); wq1.delete(); wq3.delete();
    clear_stats();
    tick();
    system_reset_n = 1'b1;
    repeat (10) tick();
    check("post_reset_wr", 64'(n_wr1 + n_wr3), 64'(0));
    check("post_reset_rd", 64'(n_rd1 + n_rd3), 64'(0));
    check("post_reset_stray", 64'(stray), 64'(0));
    check("post_reset_busy", 64'({busy1, busy3}), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
